// File: rtl/riscvstall_fetch_pkg.sv
// riscvstall fetch: shared widths and the buffered fetch entry.
// Optional same-cycle response bypass: RISCVSTALL_FETCH_BYPASS_EN.
`ifndef RISCV_INST_MSG_SZ
`define RISCV_INST_MSG_SZ 32
`endif
`ifndef RISCVSTALL_FETCH_PC_SZ
`define RISCVSTALL_FETCH_PC_SZ 32
`endif
`ifndef RISCVSTALL_FETCH_PC_INCR
`define RISCVSTALL_FETCH_PC_INCR 4
`endif
`ifndef RISCVSTALL_FETCH_ENTRY_SZ
`define RISCVSTALL_FETCH_ENTRY_SZ (`RISCV_INST_MSG_SZ + 32)
`endif

package riscvstall_fetch_pkg;

  localparam int INST_SZ = `RISCV_INST_MSG_SZ;
  localparam int PC_SZ = `RISCVSTALL_FETCH_PC_SZ;
  localparam int ENTRY_SZ = `RISCVSTALL_FETCH_ENTRY_SZ;
  localparam logic [PC_SZ-1:0] PC_INCR =
    PC_SZ'(`RISCVSTALL_FETCH_PC_INCR);

  typedef struct packed {
    logic [INST_SZ-1:0] msg;
    logic [PC_SZ-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscvstall_fetch_queue.sv
// riscvstall fetch: small FIFO with synchronous flush and occupancy count.
// Optional same-cycle response bypass: RISCVSTALL_FETCH_BYPASS_EN.
module riscvstall_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  overflow_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

  underflow_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && empty && !flush));

endmodule

// File: rtl/riscvstall_fetch_unit.sv
// riscvstall fetch stage: credit-limited imem requests, in-order buffer.
// Optional same-cycle response bypass: RISCVSTALL_FETCH_BYPASS_EN.
module riscvstall_fetch_unit
  import riscvstall_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter int          DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imemreq_val,
  input  logic               imemreq_rdy,
  output logic [31:0]        imemreq_addr,
  input  logic               imemresp_val,
  input  logic [INST_SZ-1:0] imemresp_data,
  output logic               inst_val,
  input  logic               inst_rdy,
  output logic [INST_SZ-1:0] inst_msg,
  output logic [31:0]        inst_pc,
  input  logic               redirect_val,
  input  logic [31:0]        redirect_target
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          run;
  logic [31:0]   pc_f;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] inf_cnt;
  logic [CW:0]   credit_use;
  logic          buf_empty;
  logic          buf_full;
  logic          inf_empty;
  logic          inf_full;
  logic [31:0]   inf_head;
  fetch_entry_t  buf_head;
  fetch_entry_t  buf_in;
  logic          req_fire;
  logic          resp_keep;
  logic          byp;
  logic          buf_push;
  logic          buf_pop;

  // run holds requests off until the first edge after reset release
  assign credit_use  = {1'b0, outstanding} + {1'b0, buf_cnt};
  assign imemreq_val = run && !redirect_val &&
                       (credit_use < (CW + 1)'(DEPTH));
  assign imemreq_addr = pc_f;
  assign req_fire     = imemreq_val && imemreq_rdy;
  assign resp_keep    = imemresp_val && !redirect_val &&
                        (drop_cnt == '0);

`ifdef RISCVSTALL_FETCH_BYPASS_EN
  assign byp = run && buf_empty && resp_keep;
`else
  assign byp = 1'b0;
`endif

  assign inst_val = run && !redirect_val && (!buf_empty || byp);
  assign buf_pop  = inst_val && inst_rdy && !buf_empty;
  assign buf_push = resp_keep && !(byp && inst_rdy);
  assign buf_in   = '{msg: imemresp_data, pc: inf_head};

  always_comb begin
    inst_msg = '0;
    inst_pc  = '0;
    if (!buf_empty) begin
      inst_msg = buf_head.msg;
      inst_pc  = buf_head.pc;
    end else if (byp) begin
      inst_msg = imemresp_data;
      inst_pc  = inf_head;
    end
  end

  riscvstall_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_SZ)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (redirect_val),
    .push_data (buf_in),
    .head      (buf_head),
    .count     (buf_cnt),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  riscvstall_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (req_fire),
    .pop       (imemresp_val),
    .flush     (1'b0),
    .push_data (pc_f),
    .head      (inf_head),
    .count     (inf_cnt),
    .empty     (inf_empty),
    .full      (inf_full)
  );

  // redirect wins; responses landing in that cycle are dropped too
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      pc_f        <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_val) begin
        pc_f        <= redirect_target;
        drop_cnt    <= outstanding - CW'(imemresp_val);
        outstanding <= outstanding - CW'(imemresp_val);
      end else begin
        if (req_fire) pc_f <= pc_f + PC_INCR;
        if (imemresp_val && drop_cnt != '0)
          drop_cnt <= drop_cnt - CW'(1);
        outstanding <= outstanding + CW'(req_fire)
                       - CW'(imemresp_val);
      end
    end
  end

  inflight_cnt_chk: assert property (
    @(posedge clk) disable iff (!reset_n)
    inf_cnt == outstanding);

  resp_credit_chk: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(imemresp_val && inf_empty));

  req_credit_chk: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(req_fire && inf_full));

  buf_ovf_chk: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(buf_push && buf_full && !buf_pop && !redirect_val));

endmodule

// File: tb/tb_riscvstall_fetch_unit.sv
// Bench for riscvstall_fetch_unit: memory model plus in-order scoreboard.
// Optional same-cycle response bypass: RISCVSTALL_FETCH_BYPASS_EN.
module tb_riscvstall_fetch_unit;
  import riscvstall_fetch_pkg::*;

`ifdef RISCVSTALL_FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               imemreq_val;
  logic               imemreq_rdy = 1'b1;
  logic [31:0]        imemreq_addr;
  logic               imemresp_val = 1'b0;
  logic [INST_SZ-1:0] imemresp_data = '0;
  logic               inst_val;
  logic               inst_rdy = 1'b1;
  logic [INST_SZ-1:0] inst_msg;
  logic [31:0]        inst_pc;
  logic               redirect_val = 1'b0;
  logic [31:0]        redirect_target = '0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] fire_log[$];
  logic [31:0] deq_log[$];
  logic [31:0] model_pc = 32'h1000;
  int          cyc = 0;
  int          lat = 1;
  int          first_fire = -1;
  int          first_val = -1;
  int          checks = 0;
  int          errors = 0;

  riscvstall_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imemreq_val     (imemreq_val),
    .imemreq_rdy     (imemreq_rdy),
    .imemreq_addr    (imemreq_addr),
    .imemresp_val    (imemresp_val),
    .imemresp_data   (imemresp_data),
    .inst_val        (inst_val),
    .inst_rdy        (inst_rdy),
    .inst_msg        (inst_msg),
    .inst_pc         (inst_pc),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_SZ-1:0] word(
    input logic [31:0] a
  );
    return INST_SZ'((a * 32'h9E37_79B1) ^ 32'hf8d9_8793);
  endfunction

  // one cycle: drive memory, settle, score, advance to next negedge
  task automatic tick();
    bit          resp;
    bit          fire;
    bit          ifire;
    logic [31:0] e;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imemresp_val = resp;
    imemresp_data = resp ? word(mem_q[0].addr) : '0;
    #1;
    fire = imemreq_val && imemreq_rdy;
    ifire = inst_val && inst_rdy;
    if (redirect_val) begin
      checks++;
      if (imemreq_val !== 1'b0) begin
        errors++;
        $display("FAIL redir_noreq: got %b want 0",
                 imemreq_val);
      end
      exp_q.delete();
      model_pc = redirect_target;
    end
    if (fire) begin
      checks++;
      if (imemreq_addr !== model_pc) begin
        errors++;
        $display("FAIL req_addr: got %h want %h",
                 imemreq_addr, model_pc);
      end
      if (first_fire < 0) first_fire = cyc;
      fire_log.push_back(imemreq_addr);
      exp_q.push_back(model_pc);
      mem_q.push_back('{imemreq_addr, cyc + lat});
      model_pc = model_pc + 32'd4;
    end
    if (inst_val && first_val < 0) first_val = cyc;
    if (ifire) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deq_extra: got pc %h want none",
                 inst_pc);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e || inst_msg !== word(e)) begin
          errors++;
          $display("FAIL deq: got %h/%h want %h/%h",
                   inst_pc, inst_msg, e, word(e));
        end
      end
      deq_log.push_back(inst_pc);
    end
    if (resp) void'(mem_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_val = 1'b0;
    imemresp_val = 1'b0;
    imemresp_data = '0;
    imemreq_rdy = 1'b1;
    inst_rdy = 1'b1;
    mem_q.delete();
    exp_q.delete();
    model_pc = 32'h1000;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({imemreq_val, inst_val} !== 2'b00 ||
        inst_msg !== '0 || inst_pc !== '0) begin
      errors++;
      $display("FAIL reset_out: got %b%b %h %h want 0",
               imemreq_val, inst_val, inst_msg, inst_pc);
    end
    @(negedge clk);
    do_reset();
    #1;
    checks++;
    if (imemreq_addr !== 32'h1000) begin
      errors++;
      $display("FAIL reset_pc: got %h want 00001000",
               imemreq_addr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    fire_log.delete();
    deq_log.delete();
    first_fire = -1;
    first_val = -1;
    repeat (14) tick();
    checks++;
    if (first_val - first_fire !== EXP_LAT) begin
      errors++;
      $display("FAIL stream_lat: got %0d want %0d",
               first_val - first_fire, EXP_LAT);
    end
    checks++;
    if (deq_log.size() < 3) begin
      errors++;
      $display("FAIL stream_cnt: got %0d want >=3",
               deq_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (deq_log[i] !== 32'h1000 + 32'(4 * i)) begin
          errors++;
          $display("FAIL stream_pc%0d: got %h want %h", i,
                   deq_log[i], 32'h1000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0]        hold_pc;
    logic [INST_SZ-1:0] hold_msg;
    do_reset();
    lat = 1;
    inst_rdy = 1'b0;
    fire_log.delete();
    deq_log.delete();
    repeat (5) tick();
    hold_pc = inst_pc;
    hold_msg = inst_msg;
    repeat (5) tick();
    checks++;
    if (fire_log.size() !== 2) begin
      errors++;
      $display("FAIL stall_reqs: got %0d want 2",
               fire_log.size());
    end
    checks++;
    if (imemreq_val !== 1'b0) begin
      errors++;
      $display("FAIL stall_reqval: got %b want 0",
               imemreq_val);
    end
    checks++;
    if (inst_val !== 1'b1 || inst_pc !== hold_pc ||
        inst_msg !== hold_msg || hold_pc !== 32'h1000) begin
      errors++;
      $display("FAIL stall_hold: got %b %h %h want 1 %h %h",
               inst_val, inst_pc, inst_msg, 32'h1000,
               word(32'h1000));
    end
    inst_rdy = 1'b1;
    repeat (10) tick();
    checks++;
    if (deq_log.size() < 2 || deq_log[0] !== 32'h1000 ||
        deq_log[1] !== 32'h1004) begin
      errors++;
      $display("FAIL stall_resume: got %0d entries want >=2",
               deq_log.size());
    end
  endtask

  task automatic check_stream(
    input string       tag,
    input logic [31:0] base
  );
    int bad;
    bad = 0;
    checks++;
    if (deq_log.size() == 0 || deq_log[0] !== base) begin
      errors++;
      $display("FAIL %s_first: got %h want %h", tag,
               (deq_log.size() > 0) ? deq_log[0] : 32'hx, base);
    end
    foreach (deq_log[i])
      if (deq_log[i][31:8] !== base[31:8]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_stale: got %0d stale want 0", tag, bad);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 4;
    repeat (3) tick();
    redirect_val = 1'b1;
    redirect_target = 32'h2000;
    tick();
    redirect_val = 1'b0;
    deq_log.delete();
    repeat (20) tick();
    check_stream("redir", 32'h2000);
  endtask

  task automatic test_back_to_back();
    bit found;
    do_reset();
    lat = 1;
    repeat (5) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc)
        found = 1'b1;
      else
        tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_resp: got timeout want response");
    end
    redirect_val = 1'b1;
    redirect_target = 32'h2100;
    tick();
    redirect_target = 32'h3000;
    tick();
    redirect_val = 1'b0;
    deq_log.delete();
    repeat (15) tick();
    check_stream("b2b", 32'h3000);
    checks++;
    if (dut.drop_cnt !== '0) begin
      errors++;
      $display("FAIL b2b_drop: got %0d want 0", dut.drop_cnt);
    end
  endtask

  task automatic test_wrap();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    lat = 1;
    repeat (4) tick();
    redirect_val = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_val = 1'b0;
    fire_log.delete();
    deq_log.delete();
    for (int i = 0; i < 4; i++) begin
      imemreq_rdy = pat[i];
      tick();
    end
    imemreq_rdy = 1'b1;
    repeat (8) tick();
    checks++;
    if (fire_log.size() < 2 ||
        fire_log[0] !== 32'hFFFF_FFFC ||
        fire_log[1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr: got %0d fires want fffffffc,0",
               fire_log.size());
    end
    checks++;
    if (deq_log.size() < 2 || deq_log[0] !== 32'hFFFF_FFFC ||
        deq_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_deq: got %0d entries want >=2",
               deq_log.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 3;
    repeat (3) tick();
    checks++;
    if (mem_q.size() !== 2) begin
      errors++;
      $display("FAIL mid_setup: got %0d outstanding want 2",
               mem_q.size());
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({imemreq_val, inst_val} !== 2'b00 ||
        inst_msg !== '0 || inst_pc !== '0) begin
      errors++;
      $display("FAIL mid_async: got %b%b %h %h want 0",
               imemreq_val, inst_val, inst_msg, inst_pc);
    end
    @(negedge clk);
    cyc++;
    do_reset();
    fire_log.delete();
    repeat (4) tick();
    checks++;
    if (fire_log.size() == 0 || fire_log[0] !== 32'h1000) begin
      errors++;
      $display("FAIL mid_restart: got %0d fires want 00001000",
               fire_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
